dma_ch_xfer_ctrl: RTL and testbench

DMA_CH_XFER_CTRL -- requirements
Module: dma_ch_xfer_ctrl

---
 rtl/dma_ch_xfer_ctrl_pkg.sv | 16 +
 rtl/dma_ch_xfer_ctrl_if.sv | 47 ++++
 rtl/dma_ch_xfer_ctrl_addr_step.sv | 19 +
 rtl/dma_ch_xfer_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_dma_ch_xfer_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_ch_xfer_ctrl_pkg.sv
// Shared definitions for the DMA channel transfer controller: channel state
// encoding and the largest legal beat size (log2 bytes).
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } chState_e;

    localparam logic [2:0] MAX_TRANSIZE = 3'd4;

endpackage

// File: rtl/dma_ch_xfer_ctrl_if.sv
// Command, configuration, beat and status signals of one DMA channel.
// The master side is the channel controller; the slave side is whoever
// issues commands and accepts beats.
interface dma_ch_xfer_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              enable_cmd;
    logic              disable_cmd;
    logic              stop_cmd;
    logic              pause_cmd;
    logic              resume_cmd;
    logic [2:0]        transize;
    logic [CNT_W-1:0]  srcxsize;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] des_addr;
    logic [CNT_W-1:0]  src_xaddr_inc;
    logic [CNT_W-1:0]  des_xaddr_inc;
    logic              bus_err;
    logic              beat_ready;
    logic              beat_valid;
    logic [ADDR_W-1:0] beat_src_addr;
    logic [ADDR_W-1:0] beat_des_addr;
    logic [2:0]        beat_size;
    logic              beat_last;
    logic [2:0]        ch_state;
    logic              stat_done;
    logic              stat_err;
    logic              stat_paused;

    modport master (
        input  enable_cmd, disable_cmd, stop_cmd, pause_cmd, resume_cmd,
        input  transize, srcxsize, src_addr, des_addr,
        input  src_xaddr_inc, des_xaddr_inc, bus_err, beat_ready,
        output beat_valid, beat_src_addr, beat_des_addr, beat_size, beat_last,
        output ch_state, stat_done, stat_err, stat_paused
    );

    modport slave (
        output enable_cmd, disable_cmd, stop_cmd, pause_cmd, resume_cmd,
        output transize, srcxsize, src_addr, des_addr,
        output src_xaddr_inc, des_xaddr_inc, bus_err, beat_ready,
        input  beat_valid, beat_src_addr, beat_des_addr, beat_size, beat_last,
        input  ch_state, stat_done, stat_err, stat_paused
    );

endinterface

// File: rtl/dma_ch_xfer_ctrl_addr_step.sv
// Per-beat address advance: the signed increment (counted in beats) is
// sign-extended to the address width, scaled by the beat size and added,
// wrapping modulo 2^ADDR_W.
module dma_addr_step #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [CNT_W-1:0]  inc_i,
    input  logic [2:0]        shift_i,
    output logic [ADDR_W-1:0] next_o
);

    logic [ADDR_W-1:0] incExt;

    assign incExt = ADDR_W'($signed(inc_i));
    assign next_o = addr_i + (incExt << shift_i);

endmodule

// File: rtl/dma_ch_xfer_ctrl.sv
// DMA channel transfer controller: accepts channel commands, latches the
// transfer configuration and issues one address beat per handshake until
// the beat count is exhausted, an error occurs or the channel is stopped.
// Optional feature macro: DMA_CH_PAUSE_EN enables pause/resume support.
module dma_ch_xfer_ctrl
    import dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic clk,
    input  logic rst,
    dma_ch_xfer_ctrl_if.master bus
);

    chState_e          state_q, state_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [CNT_W-1:0]  srcInc_q, srcInc_d;
    logic [CNT_W-1:0]  desInc_q, desInc_d;
    logic [ADDR_W-1:0] srcAddr_q, srcAddr_d;
    logic [ADDR_W-1:0] desAddr_q, desAddr_d;
    logic [2:0]        size_q, size_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              pausePend_q, pausePend_d;
    logic [ADDR_W-1:0] srcNext, desNext;
    logic              beatValid, handshake, haltCmd;
    logic              pauseCmd, resumeCmd;

`ifdef DMA_CH_PAUSE_EN
    assign pauseCmd    = bus.pause_cmd;
    assign resumeCmd   = bus.resume_cmd;
    assign bus.stat_paused = (state_q == PAUSE);
`else
    logic unusedPauseCmds;
    assign unusedPauseCmds = bus.pause_cmd ^ bus.resume_cmd;
    assign pauseCmd    = 1'b0;
    assign resumeCmd   = 1'b0;
    assign bus.stat_paused = 1'b0;
`endif

    dma_addr_step #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) uSrcStep (
        .addr_i (srcAddr_q),
        .inc_i  (srcInc_q),
        .shift_i(size_q),
        .next_o (srcNext)
    );

    dma_addr_step #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) uDesStep (
        .addr_i (desAddr_q),
        .inc_i  (desInc_q),
        .shift_i(size_q),
        .next_o (desNext)
    );

    assign beatValid = (state_q == RUN) || (state_q == DRAIN);
    assign handshake = beatValid && bus.beat_ready;
    assign haltCmd   = bus.disable_cmd || bus.stop_cmd;

    // Next-state and register updates; a pause request that arrives while a
    // beat is stalled is remembered until that beat is accepted.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        srcInc_d    = srcInc_q;
        desInc_d    = desInc_q;
        srcAddr_d   = srcAddr_q;
        desAddr_d   = desAddr_q;
        size_d      = size_q;
        done_d      = done_q;
        err_d       = err_q;
        pausePend_d = pausePend_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (bus.enable_cmd) begin
                    srcAddr_d   = bus.src_addr;
                    desAddr_d   = bus.des_addr;
                    size_d      = bus.transize;
                    srcInc_d    = bus.src_xaddr_inc;
                    desInc_d    = bus.des_xaddr_inc;
                    remaining_d = bus.srcxsize;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    pausePend_d = 1'b0;
                    if (bus.transize > MAX_TRANSIZE) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else if (bus.srcxsize == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.bus_err) begin
                    state_d     = ERR;
                    err_d       = 1'b1;
                    pausePend_d = 1'b0;
                end else if (haltCmd) begin
                    state_d     = handshake ? IDLE : DRAIN;
                    pausePend_d = 1'b0;
                end else if (handshake) begin
                    srcAddr_d   = srcNext;
                    desAddr_d   = desNext;
                    remaining_d = remaining_q - CNT_W'(1);
                    pausePend_d = 1'b0;
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (pauseCmd || pausePend_q) begin
                        state_d = PAUSE;
                    end
                end else if (pauseCmd) begin
                    pausePend_d = 1'b1;
                end else if (resumeCmd) begin
                    pausePend_d = 1'b0;
                end
            end
            PAUSE: begin
                if (bus.bus_err) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else if (haltCmd) begin
                    state_d = IDLE;
                end else if (!pauseCmd && resumeCmd) begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (bus.bus_err) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else if (handshake) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Channel registers, cleared asynchronously so a reset abandons any transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            srcInc_q    <= '0;
            desInc_q    <= '0;
            srcAddr_q   <= '0;
            desAddr_q   <= '0;
            size_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            pausePend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            srcInc_q    <= srcInc_d;
            desInc_q    <= desInc_d;
            srcAddr_q   <= srcAddr_d;
            desAddr_q   <= desAddr_d;
            size_q      <= size_d;
            done_q      <= done_d;
            err_q       <= err_d;
            pausePend_q <= pausePend_d;
        end
    end

    assign bus.beat_valid    = beatValid;
    assign bus.beat_src_addr = srcAddr_q;
    assign bus.beat_des_addr = desAddr_q;
    assign bus.beat_size     = size_q;
    assign bus.beat_last     = beatValid && (remaining_q == CNT_W'(1));
    assign bus.ch_state      = state_q;
    assign bus.stat_done     = done_q;
    assign bus.stat_err      = err_q;

endmodule

// File: tb/tb_dma_ch_xfer_ctrl.sv
// Self-checking bench for dma_ch_xfer_ctrl. Expected beats come from an
// arithmetic address model and are queued when a transfer is started; a
// negedge monitor compares every presented beat against the queue head.
// Honours DMA_CH_PAUSE_EN for the pause/resume scenario.
module tb_dma_ch_xfer_ctrl;
    import dma_pkg::*;

    typedef struct {
        logic [31:0] src;
        logic [31:0] des;
        logic [2:0]  size;
        logic        last;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    checks = 0;
    int    errors = 0;
    beat_t expQ[$];
    beat_t front;

    dma_ch_xfer_ctrl_if #(.ADDR_W(32), .CNT_W(16)) bus ();

    dma_ch_xfer_ctrl #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] modelAddr(logic [31:0] base, logic [15:0] inc,
                                              int size, int idx);
        longint incVal;
        longint a;
        incVal = inc[15] ? (longint'(inc) - 65536) : longint'(inc);
        a = longint'(base) + longint'(idx) * incVal * (longint'(1) << size);
        return a[31:0];
    endfunction

    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkQueueEmpty(string name);
        checkOutput(name, 64'(expQ.size()), 64'd0);
        expQ.delete();
    endtask

    task automatic applyStimulus(logic [31:0] src, logic [31:0] des, logic [2:0] size,
                                 logic [15:0] xsize, logic [15:0] sinc, logic [15:0] dinc,
                                 int nExp);
        beat_t b;
        for (int i = 0; i < nExp; i++) begin
            b.src  = modelAddr(src, sinc, int'(size), i);
            b.des  = modelAddr(des, dinc, int'(size), i);
            b.size = size;
            b.last = (i == int'(xsize) - 1);
            expQ.push_back(b);
        end
        bus.src_addr      = src;
        bus.des_addr      = des;
        bus.transize      = size;
        bus.srcxsize      = xsize;
        bus.src_xaddr_inc = sinc;
        bus.des_xaddr_inc = dinc;
        bus.enable_cmd    = 1'b1;
        step();
        bus.enable_cmd    = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.beat_valid) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpectedBeat: got src=%h des=%h, expected no beat",
                         bus.beat_src_addr, bus.beat_des_addr);
            end else begin
                front = expQ[0];
                if (bus.beat_src_addr !== front.src || bus.beat_des_addr !== front.des ||
                    bus.beat_size !== front.size || bus.beat_last !== front.last) begin
                    errors++;
                    $display("[TB] FAIL beat: got src=%h des=%h size=%0d last=%b, expected src=%h des=%h size=%0d last=%b",
                             bus.beat_src_addr, bus.beat_des_addr, bus.beat_size, bus.beat_last,
                             front.src, front.des, front.size, front.last);
                end
                if (bus.beat_ready) void'(expQ.pop_front());
            end
        end
    end

    initial begin
        logic [2:0]  rSize;
        logic [15:0] rX;
        int          budget;

        bus.enable_cmd = 0; bus.disable_cmd = 0; bus.stop_cmd = 0;
        bus.pause_cmd = 0;  bus.resume_cmd = 0;  bus.bus_err = 0;
        bus.beat_ready = 0; bus.transize = 0;    bus.srcxsize = 0;
        bus.src_addr = 0;   bus.des_addr = 0;
        bus.src_xaddr_inc = 0; bus.des_xaddr_inc = 0;

        #2;
        checkOutput("rstState", bus.ch_state, IDLE);
        checkOutput("rstValid", bus.beat_valid, 0);
        checkOutput("rstLast", bus.beat_last, 0);
        checkOutput("rstSrc", bus.beat_src_addr, 0);
        checkOutput("rstDes", bus.beat_des_addr, 0);
        checkOutput("rstSize", bus.beat_size, 0);
        checkOutput("rstDone", bus.stat_done, 0);
        checkOutput("rstErr", bus.stat_err, 0);
        checkOutput("rstPaused", bus.stat_paused, 0);
        step();
        rst = 1'b0;
        step(2);

        bus.beat_ready = 1'b1;
        applyStimulus(32'h1000, 32'h2000, 3'd2, 16'd4, 16'd1, 16'd1, 4);
        checkOutput("firstValid", bus.beat_valid, 1);
        step(3);
        checkOutput("lastFlag", bus.beat_last, 1);
        step();
        checkOutput("b2bState", bus.ch_state, DONE);
        checkOutput("b2bDone", bus.stat_done, 1);
        checkOutput("b2bValidOff", bus.beat_valid, 0);
        step(3);
        checkOutput("doneSticky", bus.stat_done, 1);
        checkQueueEmpty("b2bQueue");

        applyStimulus(32'h1, 32'h500, 3'd0, 16'd3, 16'hFFFF, 16'h2, 3);
        step(3);
        checkOutput("wrapDone", bus.stat_done, 1);
        checkQueueEmpty("wrapQueue");

        bus.beat_ready = 1'b0;
        applyStimulus(32'h4000, 32'h8000, 3'd3, 16'd4, 16'd1, 16'd1, 1);
        step(5);
        checkOutput("stallState", bus.ch_state, RUN);
        bus.stop_cmd = 1'b1;
        step();
        bus.stop_cmd = 1'b0;
        checkOutput("drainState", bus.ch_state, DRAIN);
        checkOutput("drainValid", bus.beat_valid, 1);
        step(2);
        bus.beat_ready = 1'b1;
        step();
        checkOutput("drainIdle", bus.ch_state, IDLE);
        checkOutput("drainNoDone", bus.stat_done, 0);
        checkOutput("drainValidOff", bus.beat_valid, 0);
        step(3);
        checkQueueEmpty("drainQueue");

        applyStimulus(32'hA000, 32'hB000, 3'd1, 16'd8, 16'd2, 16'hFFFE, 2);
        step();
        bus.bus_err = 1'b1;
        bus.disable_cmd = 1'b1;
        step();
        bus.bus_err = 1'b0;
        bus.disable_cmd = 1'b0;
        checkOutput("errState", bus.ch_state, ERR);
        checkOutput("errFlag", bus.stat_err, 1);
        checkOutput("errValidOff", bus.beat_valid, 0);
        step(3);
        checkOutput("errSticky", bus.stat_err, 1);
        checkQueueEmpty("errQueue");

        applyStimulus(32'hC000, 32'hD000, 3'd5, 16'd4, 16'd1, 16'd1, 0);
        checkOutput("cfgErrState", bus.ch_state, ERR);
        checkOutput("cfgErrFlag", bus.stat_err, 1);
        checkOutput("cfgErrValid", bus.beat_valid, 0);
        step(3);
        checkQueueEmpty("cfgErrQueue");
        applyStimulus(32'hC000, 32'hD000, 3'd2, 16'd0, 16'd1, 16'd1, 0);
        checkOutput("zeroState", bus.ch_state, DONE);
        checkOutput("zeroDone", bus.stat_done, 1);
        checkOutput("zeroErrClr", bus.stat_err, 0);
        checkOutput("zeroValid", bus.beat_valid, 0);
        step(3);
        checkQueueEmpty("zeroQueue");

        applyStimulus(32'h3000, 32'h7000, 3'd2, 16'd4, 16'd1, 16'd1, 4);
        step();
        bus.pause_cmd = 1'b1;
        step();
        bus.pause_cmd = 1'b0;
`ifdef DMA_CH_PAUSE_EN
        checkOutput("pauseState", bus.ch_state, PAUSE);
        checkOutput("pauseFlag", bus.stat_paused, 1);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("pauseHold%0d", i), bus.beat_valid, 0);
            step();
        end
        bus.resume_cmd = 1'b1;
        step();
        bus.resume_cmd = 1'b0;
        checkOutput("resumeState", bus.ch_state, RUN);
        checkOutput("resumeFlag", bus.stat_paused, 0);
        step(2);
`else
        checkOutput("noPauseState", bus.ch_state, RUN);
        checkOutput("noPauseFlag", bus.stat_paused, 0);
        checkOutput("noPauseValid", bus.beat_valid, 1);
        step(2);
`endif
        checkOutput("pauseDone", bus.ch_state, DONE);
        checkQueueEmpty("pauseQueue");

        applyStimulus(32'h9000, 32'h9800, 3'd0, 16'd6, 16'd1, 16'd1, 1);
        step();
        rst = 1'b1;
        #1;
        checkOutput("midRstState", bus.ch_state, IDLE);
        checkOutput("midRstValid", bus.beat_valid, 0);
        checkOutput("midRstSrc", bus.beat_src_addr, 0);
        step(2);
        rst = 1'b0;
        step(5);
        checkOutput("postRstState", bus.ch_state, IDLE);
        checkQueueEmpty("midRstQueue");

        for (int k = 0; k < 24; k++) begin
            rSize = 3'($urandom_range(0, 4));
            rX    = 16'($urandom_range(1, 8));
            bus.beat_ready = ($urandom_range(0, 3) != 0);
            applyStimulus($urandom, $urandom, rSize, rX, 16'($urandom), 16'($urandom),
                          int'(rX));
            budget = 200;
            while (!bus.stat_done && budget > 0) begin
                bus.beat_ready = ($urandom_range(0, 3) != 0);
                step();
                budget--;
            end
            checkOutput($sformatf("randDone%0d", k), bus.stat_done, 1);
            checkOutput($sformatf("randState%0d", k), bus.ch_state, DONE);
            checkQueueEmpty($sformatf("randQueue%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
